alu_cmd_sequencer: RTL and testbench

- Initiator-side controller for the team's combinational ALU. It is the end of the ALU interface that produces operands and consumes results.
- Accepts a valid/ready command stream and keeps an internal accumulator.
- Each command drives alu_a (the accumulator), alu_b (the command operand) and alu_op into an external ALU instance. The returned result and zero flag are captured and presented on a valid/ready response stream.

---
 rtl/alu_cmd_sequencer_if.sv | 26 ++
 rtl/alu_cmd_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response streams between an upstream producer and the ALU sequencer.
// The master side produces commands and consumes responses; the sequencer is the slave.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_data;
  logic             acc_clr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_data, acc_clr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_data, acc_clr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Initiator-side ALU controller: accepts one command at a time, drives an external
// combinational ALU from its accumulator, and returns the new accumulator value.
module alu_cmd_sequencer #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [2:0]           alu_op_q, alu_op_d;
  logic                 load_q, load_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

  logic             cmd_ready_int;
  logic             rsp_valid_int;
  logic             exec_en;
  logic             cmd_accept;
  logic [WIDTH-1:0] exec_value;
  logic             exec_zero;

  assign cmd_accept = bus.cmd_valid && cmd_ready_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // cmd_ready is gated by rst_n so upstream sees "not ready" while reset is held.
  always_comb begin
    cmd_ready_int = 1'b0;
    rsp_valid_int = 1'b0;
    exec_en       = 1'b0;
    unique case (state_q)
      S_IDLE:  cmd_ready_int = rst_n;
      S_EXEC:  exec_en       = 1'b1;
      S_RESP:  rsp_valid_int = 1'b1;
      default: ;
    endcase
  end

  // A load bypasses the ALU; its zero flag is the only arithmetic done here.
  assign exec_value = load_q ? alu_b_q : alu_result;
  assign exec_zero  = load_q ? (alu_b_q == '0) : alu_zero;

  always_comb begin
    acc_d      = acc_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    load_d     = load_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    op_count_d = op_count_q;
    if (cmd_accept) begin
      alu_b_d  = bus.cmd_data;
      alu_op_d = bus.cmd_op;
      load_d   = bus.cmd_load;
    end
    if (exec_en) begin
      acc_d      = exec_value;
      rsp_data_d = exec_value;
      rsp_zero_d = exec_zero;
      op_count_d = op_count_q + CNT_WIDTH'(1);
    end
    // Clear has priority over the EXEC write for the accumulator only.
    if (bus.acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      load_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      acc_q      <= acc_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      load_q     <= load_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign alu_a         = acc_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed vector table, multi-cycle corner
// sequences, and random commands checked against an accumulator-level reference model.
module tb_alu_cmd_sequencer;
  localparam int W  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(W)) bus ();

  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]    alu_op;
  logic          alu_zero;
  logic [CW-1:0] op_count;

  alu_cmd_sequencer #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .op_count   (op_count)
  );

  // External combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      3'd6: alu_result = {alu_a[W-2:0], 1'b0};
      3'd7: alu_result = {1'b0, alu_a[W-1:1]};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  acc_m;
  logic [CW-1:0] cnt_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_result(input logic ld, input logic [2:0] op,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    r  = 0;
    if (ld) return b;
    case (op)
      3'd0: r = (ai + bi) % 256;
      3'd1: r = (ai - bi + 256) % 256;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 255 - ai;
      3'd6: r = (ai * 2) % 256;
      3'd7: r = ai / 2;
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  // Full command: wait for ready, handshake, check EXEC and RESP, optional backpressure.
  task automatic send(input logic ld, input logic [2:0] op, input logic [W-1:0] data,
                      input logic clr, input int hold, input logic pend,
                      output logic [W-1:0] got, output logic got_zero, output int waits);
    logic [W-1:0] res;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.cmd_ready && waits < 20);
    if (!bus.cmd_ready) begin
      check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      got = '0;
      got_zero = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.acc_clr   = clr;
    check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("exec_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("exec_alu_a", 32'(alu_a), 32'(acc_m));
    check("exec_alu_b", 32'(alu_b), 32'(data));
    check("exec_alu_op", 32'(alu_op), 32'(op));
    res   = model_result(ld, op, acc_m, data);
    acc_m = clr ? '0 : res;
    cnt_m = cnt_m + 1'b1;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
    check("resp_valid", 32'(bus.rsp_valid), 32'd1);
    check("resp_data", 32'(bus.rsp_data), 32'(res));
    check("resp_zero", 32'(bus.rsp_zero), 32'(res == '0));
    check("resp_op_count", 32'(op_count), 32'(cnt_m));
    got      = bus.rsp_data;
    got_zero = bus.rsp_zero;
    if (pend) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = 1'b1;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 8'h3C;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_data", 32'(bus.rsp_data), 32'(res));
      check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("hold_op_count", 32'(op_count), 32'(cnt_m));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    $display("cmd ld=%0d op=%0d data=0x%02h clr=%0d hold=%0d -> rsp 0x%02h zero=%0d count=%0d",
             ld, op, data, clr, hold, got, got_zero, op_count);
  endtask

  // Reset asserted while in EXEC (phase 0) or RESP (phase 1).
  task automatic reset_mid(input int phase);
    int waits;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'h77;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.cmd_ready && waits < 20);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (phase == 1) begin
      @(posedge clk); #1;
      check("rstmid_pre_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rstmid_alu_a", 32'(alu_a), 32'd0);
    check("rstmid_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_m = '0;
    cnt_m = '0;
    #1;
    check("rstmid_release_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("rstmid_no_update", 32'(op_count), 32'd0);
    check("rstmid_rsp_data", 32'(bus.rsp_data), 32'd0);
    $display("reset mid-%s: rsp_valid=%0d acc=0x%02h count=%0d",
             (phase == 0) ? "EXEC" : "RESP", bus.rsp_valid, alu_a, op_count);
  endtask

  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [W-1:0] got;
    logic         got_zero;
    int           waits;

    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = '0;
    bus.acc_clr   = 1'b0;
    bus.rsp_ready = 1'b0;
    acc_m = '0;
    cnt_m = '0;

    vecs[0] = '{1'b1, 3'd0, 8'h0F, 8'h0F, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 8'hF1, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 3'd1, 8'h01, 8'hFF, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 8'hA5, 8'hA5, 1'b0};
    vecs[4] = '{1'b0, 3'd2, 8'h0F, 8'h05, 1'b0};
    vecs[5] = '{1'b0, 3'd3, 8'hF0, 8'hF5, 1'b0};
    vecs[6] = '{1'b0, 3'd4, 8'hFF, 8'h0A, 1'b0};
    vecs[7] = '{1'b0, 3'd5, 8'h33, 8'hF5, 1'b0};
    vecs[8] = '{1'b0, 3'd6, 8'h00, 8'hEA, 1'b0};
    vecs[9] = '{1'b0, 3'd7, 8'h00, 8'h75, 1'b0};

    // Reset state
    #12;
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    check("reset_alu_a", 32'(alu_a), 32'd0);
    check("reset_alu_b", 32'(alu_b), 32'd0);
    check("reset_alu_op", 32'(alu_op), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    $display("reset released: cmd_ready=%0d count=%0d", bus.cmd_ready, op_count);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].ld, vecs[i].op, vecs[i].data, 1'b0, 0, 1'b0, got, got_zero, waits);
      check("vec_data", 32'(got), 32'(vecs[i].exp_data));
      check("vec_zero", 32'(got_zero), 32'(vecs[i].exp_zero));
    end

    // Backpressure with a pending command, then prompt acceptance
    send(1'b0, 3'd0, 8'h01, 1'b0, 5, 1'b1, got, got_zero, waits);
    send(1'b1, 3'd0, 8'h3C, 1'b0, 0, 1'b0, got, got_zero, waits);
    check("bp_accept_wait", 32'(waits), 32'd1);
    check("bp_data", 32'(got), 32'h3C);

    // acc_clr coinciding with EXEC
    send(1'b1, 3'd0, 8'h10, 1'b0, 0, 1'b0, got, got_zero, waits);
    send(1'b0, 3'd0, 8'h01, 1'b1, 0, 1'b0, got, got_zero, waits);
    check("clr_rsp_data", 32'(got), 32'h11);
    send(1'b0, 3'd3, 8'h00, 1'b0, 0, 1'b0, got, got_zero, waits);
    check("clr_next_result", 32'(got), 32'h00);
    check("clr_next_zero", 32'(got_zero), 32'd1);

    // Reset in the middle of a transaction
    reset_mid(0);
    reset_mid(1);

    // Counter wrap
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    cnt_m = 16'hFFFF;
    check("wrap_preload", 32'(op_count), 32'hFFFF);
    send(1'b1, 3'd0, 8'h5A, 1'b0, 0, 1'b0, got, got_zero, waits);
    check("wrap_count", 32'(op_count), 32'd0);

    // Random commands against the reference model
    for (int n = 0; n < 150; n++) begin
      send(($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)), W'($urandom),
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)), 1'b0,
           got, got_zero, waits);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
